// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;
    logic [7:0] xor_q, xor_d;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [23:0]        asm_q, asm_d;
    logic [1:0]         idx_q, idx_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               accept;
    logic [CNT_W-1:0]   len_full;
    logic [31:0]        word;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            words_q   <= '0;
            asm_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            words_q   <= words_d;
            asm_q     <= asm_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        words_d   = words_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        error_d   = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        rx_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA) || (state_q == S_CHECK);
`else
        rx_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA);
`endif
        accept    = rx_valid && rx_ready;
        len_full  = {len_q[CNT_W-9:0], rx_data};
        word      = {asm_q, rx_data};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = '0;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = CNT_W'(rx_data);
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else if (len_full > DEPTH_C) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d = word[23:0];
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    // Fourth byte completes a word; the write is registered so it appears next cycle.
                    if (idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word;
                        wr_addr_d = 32'(words_q) << 2;
                        words_d   = words_q + CNT_W'(1);
                        if (words_q + CNT_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven self-checking bench for imem_loader
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];

    typedef struct {
        string            name;
        int               n;
        logic [0:11][7:0] b;
        int               gap;
        int               nw;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic             exp_done;
        logic             exp_err;
        logic             exp_hold;
        logic [15:0]      exp_words;
    } vec_t;

    vec_t vecs[$];

    imem_loader #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin
            @(posedge clock); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (rx_ready === 1'b1) ok = 1;
            @(posedge clock); #1;
        end
        rx_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted, expected acceptance within 20 cycles", b);
        end
    endtask

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
    endtask

    initial begin
        // Reset with rx_valid high: nothing may be accepted or written.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);

        vecs.push_back('{"normal", 10 + CK,
            {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55, 8'h00},
            0, 2, 32'h20080005, 32'h01095020, 1'b1, 1'b0, 1'b0, 16'd2});
        vecs.push_back('{"zero_len", 2 + CK,
            {8'h00, 8'h00, 8'h00, 72'h0},
            0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{"oversize", 2,
            {8'h01, 8'h01, 80'h0},
            0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd0});
        vecs.push_back('{"gapped", 10 + CK,
            {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55, 8'h00},
            3, 2, 32'h20080005, 32'h01095020, 1'b1, 1'b0, 1'b0, 16'd2});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{"bad_cksum", 11,
            {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h54, 8'h00},
            0, 2, 32'h20080005, 32'h01095020, 1'b0, 1'b1, 1'b1, 16'd2});
`endif

        foreach (vecs[v]) begin
            clear_log();
            do_start();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i], vecs[v].gap);
            repeat (3) @(negedge clock);
            chk({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
            chk({vecs[v].name, "_error"}, 32'(error), 32'(vecs[v].exp_err));
            chk({vecs[v].name, "_cpu_hold"}, 32'(cpu_hold), 32'(vecs[v].exp_hold));
            chk({vecs[v].name, "_words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
            chk({vecs[v].name, "_rx_ready"}, 32'(rx_ready), 32'd0);
            chk({vecs[v].name, "_nwrites"}, 32'(wa_log.size()), 32'(vecs[v].nw));
            for (int w = 0; w < wa_log.size() && w < vecs[v].nw; w++) begin
                chk({vecs[v].name, "_addr"}, wa_log[w], 32'(w * 4));
                chk({vecs[v].name, "_data"}, wd_log[w], (w == 0) ? vecs[v].w0 : vecs[v].w1);
            end
            @(posedge clock); #1;
        end

        // Single-word frame: write and completion land one cycle after the 4th data byte.
        clear_log();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        @(negedge clock);
        chk("lat_wr_en", 32'(wr_en), 32'd1);
        chk("lat_wr_addr", wr_addr, 32'h0);
        chk("lat_wr_data", wr_data, 32'hDEADBEEF);
        chk("lat_words", 32'(words_loaded), 32'd1);
        chk("lat_rx_ready", 32'(rx_ready), 32'(CK));
        chk("lat_done", 32'(done), 32'(1 - CK));
        chk("lat_cpu_hold", 32'(cpu_hold), 32'(CK));
        @(negedge clock);
        chk("lat_wr_en_drop", 32'(wr_en), 32'd0);
        chk("lat_wr_data_hold", wr_data, 32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(posedge clock); #1;
        send_byte(8'h22, 0);
        @(negedge clock);
        chk("lat_ck_done", 32'(done), 32'd1);
        chk("lat_ck_cpu_hold", 32'(cpu_hold), 32'd0);
`endif
        chk("lat_nwrites", 32'(wa_log.size()), 32'd1);
        @(posedge clock); #1;

        // Reset after two data bytes aborts the load.
        clear_log();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (6) @(negedge clock);
        rx_valid = 1'b0;
        chk("abort_nwrites", 32'(wa_log.size()), 32'd0);
        chk("abort_rx_ready", 32'(rx_ready), 32'd0);
        chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
